// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies a synchronized lock, retries on timeout, gates sys_rst.
// Optional saturating lock-loss counter is built only when PLL_SEQ_LOCK_LOSS_CNT_EN is defined.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       relock_ack,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_A   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (CNT_A > LOCK_TIMEOUT_CYCLES) ? CNT_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lock_meta;
  logic          r_locked_s;
  logic          r_pending;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_relock_ack;
  logic          r_fault;
  logic [3:0]    r_retry_cnt;
  logic [3:0]    w_retry_next;

  assign w_retry_next = r_retry_cnt + 4'd1;

  // Only this synchronizer ever samples the raw lock input.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_locked_s  <= r_lock_meta;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_relock_ack <= 1'b0;
      r_fault      <= 1'b0;
      r_retry_cnt  <= 4'd0;
    end else begin
      r_relock_ack <= 1'b0;
      r_cnt        <= r_cnt + CW'(1);
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TMO_LAST) begin
            r_cnt       <= '0;
            r_retry_cnt <= w_retry_next;
            r_pll_rst   <= 1'b1;
            if (w_retry_next == RETRY_LIMIT) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          // Any drop restarts qualification and the lock timeout from scratch.
          if (!r_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STB_LAST) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_sys_rst    <= 1'b0;
            r_ready      <= 1'b1;
            r_retry_cnt  <= 4'd0;
            r_relock_ack <= r_pending;
            r_pending    <= 1'b0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt;
          if (!r_locked_s || relock_req) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_pending <= r_pending | relock_req;
          end
        end
        S_FAULT: begin
          r_cnt <= r_cnt;
          if (relock_req) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_fault     <= 1'b0;
            r_retry_cnt <= 4'd0;
            r_pending   <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_RESET_PLL;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] r_lock_loss_cnt;

  // Counts lock-driven RUN exits, including ones that coincide with a relock request.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (r_state == S_RUN && !r_locked_s && r_lock_loss_cnt != 8'hFF) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst    = r_pll_rst;
  assign sys_rst    = r_sys_rst;
  assign ready      = r_ready;
  assign relock_ack = r_relock_ack;
  assign fault      = r_fault;
  assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: every output change is matched against a queued expected edge/value.
module tb_pll_lock_sequencer;
  localparam int RPC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MR  = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       relock_ack;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RPC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .relock_ack   (relock_ack),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [16:0] vec;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_llc  = 0;
  int   r;

  function automatic logic [16:0] mk(input logic pr, input logic sr, input logic rdy,
                                     input logic ack, input logic flt,
                                     input logic [3:0] rc, input int llc);
    logic [7:0] l;
    l = 8'(llc);
    return {pr, sr, rdy, ack, flt, rc, l};
  endfunction

  task automatic expect_at(input int e, input logic [16:0] v, input string tag);
    exp_t x;
    x.edge_n = e;
    x.vec    = v;
    x.tag    = tag;
    exp_q.push_back(x);
  endtask

  task automatic goto_edge(input int n);
    while (cyc < n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic loss_inc();
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    m_llc = (m_llc >= 255) ? 255 : m_llc + 1;
`endif
  endtask

  logic [16:0] obs;
  logic [16:0] prev;
  assign obs = {pll_rst, sys_rst, ready, relock_ack, fault, retry_cnt, lock_loss_cnt};

  // Monitor: each change of the output vector is one presented response.
  always @(negedge refclk) begin
    exp_t x;
    if (obs !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d outputs %h, required no change from %h", cyc, obs, prev);
      end else begin
        x = exp_q.pop_front();
        if (x.edge_n != cyc || x.vec !== obs) begin
          errors++;
          $display("FAIL %s: edge %0d outputs %h, required edge %0d outputs %h", x.tag, cyc, obs, x.edge_n, x.vec);
        end
      end
    end
    prev = obs;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    expect_at(1, mk(1, 1, 0, 0, 0, 0, 0), "reset_state");
    goto_edge(3);
    rst = 1'b0;
    expect_at(7, mk(0, 1, 0, 0, 0, 0, m_llc), "pll_rst_fall");
    goto_edge(8);  relock_req = 1'b1;   // ignored in WAIT_LOCK
    goto_edge(9);  relock_req = 1'b0;
    goto_edge(12); pll_locked = 1'b1;
    expect_at(23, mk(0, 0, 1, 0, 0, 0, m_llc), "first_run");

    // relock in RUN with lock held
    goto_edge(25); relock_req = 1'b1;
    expect_at(26, mk(1, 1, 0, 0, 0, 0, m_llc), "relock_rst");
    expect_at(30, mk(0, 1, 0, 0, 0, 0, m_llc), "relock_wait");
    expect_at(39, mk(0, 0, 1, 1, 0, 0, m_llc), "relock_ack");
    expect_at(40, mk(0, 0, 1, 0, 0, 0, m_llc), "relock_ack_end");
    goto_edge(26); relock_req = 1'b0;

    // relock, then a 3-cycle glitch during STABLE
    goto_edge(44); relock_req = 1'b1; pll_locked = 1'b0;
    expect_at(45, mk(1, 1, 0, 0, 0, 0, m_llc), "glitch_relock_rst");
    expect_at(49, mk(0, 1, 0, 0, 0, 0, m_llc), "glitch_wait");
    goto_edge(45); relock_req = 1'b0;
    goto_edge(51); pll_locked = 1'b1;
    goto_edge(56); pll_locked = 1'b0;
    goto_edge(59); pll_locked = 1'b1;
    expect_at(70, mk(0, 0, 1, 1, 0, 0, m_llc), "glitch_run_ack");
    expect_at(71, mk(0, 0, 1, 0, 0, 0, m_llc), "glitch_ack_end");

    // lock loss coincident with relock request
    goto_edge(74); pll_locked = 1'b0;
    goto_edge(76); relock_req = 1'b1;
    loss_inc();
    expect_at(77, mk(1, 1, 0, 0, 0, 0, m_llc), "loss_relock_rst");
    expect_at(81, mk(0, 1, 0, 0, 0, 0, m_llc), "loss_relock_wait");
    goto_edge(77); relock_req = 1'b0;
    goto_edge(82); pll_locked = 1'b1;
    expect_at(93, mk(0, 0, 1, 1, 0, 0, m_llc), "loss_relock_ack");
    expect_at(94, mk(0, 0, 1, 0, 0, 0, m_llc), "loss_relock_ack_end");

    // lock loss, two timeouts, FAULT, relock out of FAULT
    goto_edge(96); pll_locked = 1'b0;
    loss_inc();
    expect_at(99,  mk(1, 1, 0, 0, 0, 0, m_llc), "loss_rst");
    expect_at(103, mk(0, 1, 0, 0, 0, 0, m_llc), "loss_wait");
    expect_at(135, mk(1, 1, 0, 0, 0, 1, m_llc), "timeout1");
    expect_at(139, mk(0, 1, 0, 0, 0, 1, m_llc), "timeout1_wait");
    expect_at(171, mk(1, 1, 0, 0, 1, 2, m_llc), "fault");
    goto_edge(109); relock_req = 1'b1;
    goto_edge(110); relock_req = 1'b0;
    goto_edge(180); relock_req = 1'b1;
    expect_at(181, mk(1, 1, 0, 0, 0, 0, m_llc), "fault_exit");
    expect_at(185, mk(0, 1, 0, 0, 0, 0, m_llc), "fault_exit_wait");
    goto_edge(181); relock_req = 1'b0;
    goto_edge(186); pll_locked = 1'b1;
    expect_at(197, mk(0, 0, 1, 1, 0, 0, m_llc), "fault_relock_ack");
    expect_at(198, mk(0, 0, 1, 0, 0, 0, m_llc), "fault_relock_ack_end");

    // rst mid-STABLE with a relock pending: no ack afterwards
    goto_edge(199); relock_req = 1'b1;
    expect_at(200, mk(1, 1, 0, 0, 0, 0, m_llc), "pend_rst");
    expect_at(204, mk(0, 1, 0, 0, 0, 0, m_llc), "pend_wait");
    goto_edge(200); relock_req = 1'b0;
    goto_edge(207); #2;
    m_llc = 0;
    expect_at(207, mk(1, 1, 0, 0, 0, 0, 0), "rst_mid_stable");
    rst = 1'b1;
    goto_edge(209); rst = 1'b0;
    expect_at(213, mk(0, 1, 0, 0, 0, 0, 0), "rst_stable_wait");
    expect_at(222, mk(0, 0, 1, 0, 0, 0, 0), "rst_stable_run_noack");

    // rst mid-RUN
    goto_edge(226); #2;
    expect_at(226, mk(1, 1, 0, 0, 0, 0, 0), "rst_mid_run");
    rst = 1'b1;
    goto_edge(228); rst = 1'b0;
    expect_at(232, mk(0, 1, 0, 0, 0, 0, 0), "rst_run_wait");
    expect_at(241, mk(0, 0, 1, 0, 0, 0, 0), "rst_run_run");

    // 300 lock losses: counter saturates when enabled
    r = 241;
    for (int i = 0; i < 300; i++) begin
      goto_edge(r + 1); pll_locked = 1'b0;
      loss_inc();
      expect_at(r + 4, mk(1, 1, 0, 0, 0, 0, m_llc), "sat_loss_rst");
      expect_at(r + 8, mk(0, 1, 0, 0, 0, 0, m_llc), "sat_loss_wait");
      goto_edge(r + 8); pll_locked = 1'b1;
      expect_at(r + 19, mk(0, 0, 1, 0, 0, 0, m_llc), "sat_loss_run");
      r = r + 19;
    end
    goto_edge(r + 3);

    checks++;
    if (lock_loss_cnt !== 8'(m_llc)) begin
      errors++;
      $display("FAIL lock_loss_final: got %0d, required %0d", lock_loss_cnt, m_llc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected changes never seen, required 0 (next %s at edge %0d)",
               exp_q.size(), exp_q[0].tag, exp_q[0].edge_n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
